bus_responder: RTL

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_pkg.sv | 18 +
 rtl/console_fifo.sv | 44 ++++
 rtl/bus_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the bus responder: FSM encoding, console register
// offsets and console FIFO sizing.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] CONSOLE_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] CONSOLE_STAT_OFS = 32'h0000_0004;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
    localparam int FIFO_CW    = 3;

endpackage

// File: rtl/console_fifo.sv
// Four-entry byte FIFO feeding the console stream; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module console_fifo
    import bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [7:0]         push_data,
    input  logic               pop,
    output logic [7:0]         data,
    output logic [FIFO_CW-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               do_push, do_pop;

    assign full    = (count == FIFO_CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = empty ? 8'h00 : mem[rd_ptr];

    // Pointers are exactly FIFO_AW bits wide so they wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_responder.sv
// Single-outstanding bus target: word RAM plus optional console MMIO
// (enabled with BUS_RESPONDER_CONSOLE_EN), fixed wait states before ack.
module bus_responder
    import bus_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int          IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [29:0] CDATA_W = 30'((MMIO_BASE + CONSOLE_DATA_OFS) >> 2);
    localparam logic [29:0] CSTAT_W = 30'((MMIO_BASE + CONSOLE_STAT_OFS) >> 2);

    logic [31:0] mem [MEM_WORDS];

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        lat_rw;
    logic [29:0] lat_word;
    logic [31:0] lat_wdata;

    logic        cur_rw;
    logic [29:0] cur_word;
    logic [31:0] cur_wdata;
    logic        is_ram, is_cdata, is_cstat;
    logic        stall, commit;
    logic [IDX_W-1:0] ram_idx;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    // In IDLE the access is taken straight from the bus so a zero-wait
    // access can commit on the acceptance cycle.
    assign cur_rw    = (state == IDLE) ? rw          : lat_rw;
    assign cur_word  = (state == IDLE) ? addr[31:2]  : lat_word;
    assign cur_wdata = (state == IDLE) ? wdata       : lat_wdata;
    assign is_ram    = ({2'b00, cur_word} < 32'(MEM_WORDS));
    assign ram_idx   = cur_word[IDX_W-1:0];

`ifdef BUS_RESPONDER_CONSOLE_EN
    logic [FIFO_CW-1:0] fifo_count;
    logic               fifo_full, fifo_empty, fifo_pop;

    assign is_cdata = !is_ram && (cur_word == CDATA_W);
    assign is_cstat = !is_ram && (cur_word == CSTAT_W);
    assign fifo_pop = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;
    assign stall    = cur_rw && is_cdata && fifo_full && !fifo_pop;

    console_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (commit && !reset && cur_rw && is_cdata),
        .push_data (cur_wdata[7:0]),
        .pop       (fifo_pop),
        .data      (tx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    logic unused_console;

    assign unused_console = tx_ready ^ (^CDATA_W) ^ (^CSTAT_W);
    assign is_cdata = 1'b0;
    assign is_cstat = 1'b0;
    assign stall    = 1'b0;
    assign tx_valid = 1'b0;
    assign tx_data  = 8'h00;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        unique case (state)
            IDLE: if (req) begin
                cnt_nxt = 3'(WAIT_STATES);
                if (WAIT_STATES == 0 && !stall) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1 && !stall) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            lat_rw    <= rw;
            lat_word  <= addr[31:2];
            lat_wdata <= wdata;
        end
    end

    // RAM is deliberately not reset; a reset during an access blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_rw && is_ram) mem[ram_idx] <= cur_wdata;
    end

    always_comb begin
        ack   = (state == RESP);
        rdata = 32'h0;
        err   = 1'b0;
        if (state == RESP) begin
            err = !(is_ram || is_cdata || is_cstat);
            if (!lat_rw) begin
                if (is_ram) rdata = mem[ram_idx];
`ifdef BUS_RESPONDER_CONSOLE_EN
                else if (is_cstat) rdata = {29'b0, fifo_count};
`endif
            end
        end
    end

endmodule
